// File: rtl/axis_arb_pkg.sv
// Shared constants for the AXI-Stream round-robin arbiter.
// State encoding, beat counter width and index-width helper.
package axis_arb_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    localparam int BEAT_CNT_W = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_arb_out_reg.sv
// One-entry registered AXI-Stream stage: load, hold while stalled, drain.
// The caller only asserts load when the stage is empty or draining.
module axis_out_reg
    import axis_arb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] dout
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin burst arbiter merging NUM_SRC AXI-Stream sources.
// Define ARB_FIXED_PRIORITY_EN to make IDLE pick the lowest-index source.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SRC    = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            S_AXIS_TVALID,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] S_AXIS_TDATA,
    output logic [NUM_SRC-1:0]            S_AXIS_TREADY,
    output logic                          M_AXIS_TVALID,
    output logic [DATA_WIDTH-1:0]         M_AXIS_TDATA,
    output logic [$clog2(NUM_SRC)-1:0]    M_AXIS_TDEST,
    input  logic                          M_AXIS_TREADY,
    output logic [NUM_SRC-1:0]            grant,
    output logic                          busy
);

    localparam int IDX_W = idx_w(NUM_SRC);

    logic                  state;
    logic [IDX_W-1:0]      last;
    logic [BEAT_CNT_W-1:0] cnt;
    logic [IDX_W-1:0]      g_idx;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_found;
    logic                  out_ready;
    logic                  g_valid;
    logic                  accept;
    logic                  last_beat;

`ifdef ARB_FIXED_PRIORITY_EN
    function automatic logic [IDX_W:0] pick(
        input logic [NUM_SRC-1:0] req,
        input logic [IDX_W-1:0]   ptr
    );
        logic [IDX_W:0] res;
        res = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) res = {1'b1, IDX_W'(i)};
        end
        return res;
    endfunction
`else
    // Scan downward so the nearest requester after ptr wins.
    function automatic logic [IDX_W:0] pick(
        input logic [NUM_SRC-1:0] req,
        input logic [IDX_W-1:0]   ptr
    );
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_SRC;
            if (req[idx]) res = {1'b1, IDX_W'(idx)};
        end
        return res;
    endfunction
`endif

    always_comb begin
        {pick_found, pick_idx} = pick(S_AXIS_TVALID, last);
    end

    always_comb begin
        g_idx    = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                g_idx    = IDX_W'(i);
                sel_data = S_AXIS_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign busy      = (state == ST_GRANT);
    assign out_ready = ~M_AXIS_TVALID | M_AXIS_TREADY;
    assign S_AXIS_TREADY = (busy && out_ready && !rst) ? grant : '0;
    assign g_valid   = |(S_AXIS_TVALID & grant);
    assign accept    = |(S_AXIS_TVALID & S_AXIS_TREADY);
    assign last_beat = (cnt == BEAT_CNT_W'(BURST_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            grant <= '0;
            last  <= IDX_W'(NUM_SRC - 1);
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        state <= ST_GRANT;
                        grant <= NUM_SRC'(1) << pick_idx;
                        last  <= pick_idx;
                        cnt   <= '0;
                    end
                end
                ST_GRANT: begin
                    if (!g_valid) begin
                        state <= ST_IDLE;
                        grant <= '0;
                    end else if (accept) begin
                        if (last_beat) begin
                            state <= ST_IDLE;
                            grant <= '0;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    axis_out_reg #(
        .W(IDX_W + DATA_WIDTH)
    ) u_out (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .din  ({g_idx, sel_data}),
        .ready(M_AXIS_TREADY),
        .valid(M_AXIS_TVALID),
        .dout ({M_AXIS_TDEST, M_AXIS_TDATA})
    );

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: directed source queues feed the DUT,
// expected beats are queued up front and a negedge monitor checks them.
module tb_axis_rr_arbiter;

    localparam int DW = 8;
    localparam int NS = 4;
    localparam int BL = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NS-1:0]    S_AXIS_TVALID;
    logic [NS*DW-1:0] S_AXIS_TDATA;
    logic [NS-1:0]    S_AXIS_TREADY;
    logic             M_AXIS_TVALID;
    logic [DW-1:0]    M_AXIS_TDATA;
    logic [1:0]       M_AXIS_TDEST;
    logic             M_AXIS_TREADY;
    logic [NS-1:0]    grant;
    logic             busy;

    axis_rr_arbiter #(
        .DATA_WIDTH(DW),
        .NUM_SRC   (NS),
        .BURST_LEN (BL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TDATA (S_AXIS_TDATA),
        .S_AXIS_TREADY(S_AXIS_TREADY),
        .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TDATA (M_AXIS_TDATA),
        .M_AXIS_TDEST (M_AXIS_TDEST),
        .M_AXIS_TREADY(M_AXIS_TREADY),
        .grant        (grant),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            stall_pat = 0;
    logic [NS-1:0] en;
    logic [7:0]    srcq[NS][$];
    logic [9:0]    expq[$];
    time           hs[$];
    logic [9:0]    prev_pl;
    bit            prev_stall = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_payload", {M_AXIS_TDEST, M_AXIS_TDATA}, prev_pl);
                chk("hold_valid", M_AXIS_TVALID, 1);
            end
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                hs.push_back($time);
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got %0h, required none",
                             {M_AXIS_TDEST, M_AXIS_TDATA});
                end else begin
                    chk("beat", {M_AXIS_TDEST, M_AXIS_TDATA},
                        expq.pop_front());
                end
            end
            prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
            prev_pl    = {M_AXIS_TDEST, M_AXIS_TDATA};
        end
    end

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            S_AXIS_TVALID[i] = en[i] && (srcq[i].size() > 0);
            S_AXIS_TDATA[i*DW +: DW] =
                (srcq[i].size() > 0) ? srcq[i][0] : 8'h00;
        end
        M_AXIS_TREADY = stall_pat ? !((cyc % 7) inside {5, 6}) : 1'b1;
    endtask

    task automatic step(output logic [NS-1:0] acc);
        @(negedge clk);
        acc = S_AXIS_TVALID & S_AXIS_TREADY;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (acc[i]) void'(srcq[i].pop_front());
        end
        cyc++;
        drive();
    endtask

    function automatic bit pending();
        for (int i = 0; i < NS; i++) begin
            if (en[i] && srcq[i].size() > 0) return 1;
        end
        return 0;
    endfunction

    task automatic run(input int budget, input string name);
        int            n;
        logic [NS-1:0] a;
        n = 0;
        drive();
        while ((pending() || expq.size() != 0) && n < budget) begin
            step(a);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d beats left, required 0",
                     name, expq.size());
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < NS; i++) srcq[i].delete();
    endtask

    task automatic load(input int s, input int base, input int n);
        for (int k = 0; k < n; k++) srcq[s].push_back(8'(base + k));
    endtask

    task automatic expect_beat(input int dest, input int data);
        expq.push_back({2'(dest), 8'(data)});
    endtask

    task automatic do_reset(input bit check);
        rst = 1'b1;
        expq.delete();
        drive();
        @(posedge clk);
        @(negedge clk);
        if (check) begin
            chk("rst_m_valid", M_AXIS_TVALID, 0);
            chk("rst_s_ready", S_AXIS_TREADY, 0);
            chk("rst_grant", grant, 0);
            chk("rst_busy", busy, 0);
            chk("rst_m_data", M_AXIS_TDATA, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        hs.delete();
        drive();
    endtask

    task automatic fairness(input bit stall, input string name);
        clear_src();
        en = '0;
        stall_pat = 0;
        do_reset(0);
        for (int s = 0; s < NS; s++) load(s, s * 16, 8);
`ifdef ARB_FIXED_PRIORITY_EN
        for (int s = 0; s < NS; s++)
            for (int k = 0; k < 8; k++) expect_beat(s, s * 16 + k);
`else
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < NS; s++)
                for (int k = 0; k < BL; k++)
                    expect_beat(s, s * 16 + r * BL + k);
`endif
        stall_pat = stall;
        en = '1;
        run(400, name);
        stall_pat = 0;
    endtask

    initial begin
        logic [NS-1:0] a;
        int            nacc;

        rst = 1'b1;
        en = '0;
        S_AXIS_TVALID = '0;
        S_AXIS_TDATA = '0;
        M_AXIS_TREADY = 1'b1;

        // Reset with every source valid, then first grant goes to source 0
        clear_src();
        for (int s = 0; s < NS; s++) load(s, s * 16, 8);
        en = '1;
        do_reset(1);
        @(negedge clk);
        chk("arb_cycle_grant", grant, 0);
        chk("arb_cycle_ready", S_AXIS_TREADY, 0);
        @(negedge clk);
        chk("first_grant", grant, 4'b0001);
        chk("first_busy", busy, 1);

        // Single source 1 sends 1..8
        clear_src();
        en = '0;
        do_reset(0);
        load(1, 1, 8);
        for (int k = 1; k <= 8; k++) expect_beat(1, k);
        en = 4'b0010;
        run(100, "single");
        if (hs.size() >= 6) begin
            chk("single_gap_1_2", 32'(hs[1] - hs[0]), 10);
            chk("single_gap_4_5", 32'(hs[4] - hs[3]), 20);
            chk("single_gap_5_6", 32'(hs[5] - hs[4]), 10);
        end else begin
            checks++;
            errors++;
            $display("FAIL single_count: got %0d beats, required 8",
                     hs.size());
        end

        fairness(0, "fair");
        fairness(1, "backpressure");

        // Idle-release: source 2 has only 2 beats, source 3 waiting
        clear_src();
        en = '0;
        do_reset(0);
        load(2, 8'h21, 2);
        load(3, 8'h31, 4);
        expect_beat(2, 8'h21);
        expect_beat(2, 8'h22);
        for (int k = 0; k < 4; k++) expect_beat(3, 8'h31 + k);
        en = 4'b1100;
        run(100, "idle_release");
        if (hs.size() >= 3) begin
            chk("release_gap", 32'(hs[2] - hs[1]), 30);
        end else begin
            checks++;
            errors++;
            $display("FAIL release_count: got %0d beats, required 6",
                     hs.size());
        end

        // Sources 0 and 3 always valid
        clear_src();
        en = '0;
        do_reset(0);
        load(0, 8'h00, 8);
        load(3, 8'h30, 8);
`ifdef ARB_FIXED_PRIORITY_EN
        for (int k = 0; k < 8; k++) expect_beat(0, k);
        for (int k = 0; k < 8; k++) expect_beat(3, 8'h30 + k);
`else
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < BL; k++) expect_beat(0, r * BL + k);
            for (int k = 0; k < BL; k++) expect_beat(3, 8'h30 + r * BL + k);
        end
`endif
        en = 4'b1001;
        run(100, "pair");

        // Reset in the middle of a source-1 burst
        clear_src();
        en = '0;
        do_reset(0);
        load(1, 8'h10, 8);
        expect_beat(1, 8'h10);
        en = 4'b0010;
        drive();
        nacc = 0;
        for (int n = 0; n < 20 && nacc < 2; n++) begin
            step(a);
            if (a[1]) nacc++;
        end
        chk("midburst_reached", nacc, 2);
        rst = 1'b1;
        drive();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_m_valid", M_AXIS_TVALID, 0);
        chk("midrst_grant", grant, 0);
        chk("midrst_s_ready", S_AXIS_TREADY, 0);
        chk("midrst_drained", expq.size(), 0);
        clear_src();
        expq.delete();
        load(0, 8'h01, 2);
        load(2, 8'h25, 2);
        expect_beat(0, 8'h01);
        expect_beat(0, 8'h02);
        expect_beat(2, 8'h25);
        expect_beat(2, 8'h26);
        en = 4'b0101;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        run(100, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
